wrr_burst_arbiter: RTL and testbench
====================================

Name: wrr_burst_arbiter

Overview:
- Weighted round-robin arbiter that shares one downstream resource among CLIENTS requesters.
- Each grant is held for up to weight[i] consumed beats, then moves to the next requester in rotating priority order.
- Sits in front of the shared datapath. A global stall freezes all arbitration state.
- Exports last_selected so formal properties can check that state is stable during stall.

Parameters:
- CLIENTS, 8, number of requesters (2..32)
- CLIENTS_W, $clog2(CLIENTS), width of client index
- WEIGHT_W, 4, width of per-client beat weight

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- request  in  CLIENTS  per-client request; stays high until that client is granted
- weight  in  CLIENTS*WEIGHT_W  per-client burst weight, quasi-static; slice i is weight[i*WEIGHT_W +: WEIGHT_W]
- beat_done  in  1  granted client consumed one beat this cycle
- stall  in  1  freeze arbitration and beat counting
- grant  out  CLIENTS  one-hot or zero, registered
- grant_valid  out  1  equals |grant
- grant_id  out  CLIENTS_W  index of granted client; 0 when grant_valid=0
- last_selected  out  CLIENTS_W  index of most recently granted client

Behaviour:
- Reset (synchronous, clock edge with reset=1), and reset mid-burst:
  - grant=0, grant_valid=0, grant_id=0
  - last_selected=CLIENTS-1, so client 0 has priority first
  - beat counter=0, FSM=IDLE
- FSM states: IDLE, BURST.
- Pick function:
  - Search starts at index last_selected+1 and wraps modulo CLIENTS.
  - The first index with request[i]=1 wins.
- IDLE:
  - If stall=0 and |request: register grant for the pick, set last_selected=pick, load cnt=max(weight[pick],1), go to BURST.
  - Grant is visible 1 cycle after the request is seen.
  - Otherwise remain in IDLE with grant=0.
- BURST, when stall=0:
  - beat_done=1 decrements cnt.
  - Release condition: (beat_done && cnt==1) or request[grant_id]==0.
  - On release with another requester present: load the next pick in the same cycle. The next grant appears on the following cycle with no idle bubble.
  - On release with no other requester: if request[grant_id] is still 1, re-grant that client and reload cnt; otherwise go to IDLE.
- stall=1, in any state:
  - grant, grant_id, cnt, last_selected and FSM state are held unchanged.
  - beat_done is ignored.
  - New requests are not arbitrated.
- Weight value 0 is treated as 1.
- A weight change takes effect only at the next cnt load.
- Invariants:
  - $onehot0(grant)
  - grant implies request at the same index, except in the single cycle after a request drop
  - cnt never underflows
- Fairness: a continuously requesting client is granted within (CLIENTS-1) bursts.

Optional Feature:
- Macro: WRR_ARB_LOCK_EN
- Defined:
  - Adds input lock (1 bit).
  - In BURST, while lock=1, weight-expiry release is suppressed and cnt saturates at 1.
  - Release occurs only on lock=0 with the normal release condition, or on request drop.
- Undefined: no lock port; behaviour is exactly as above.

Decomposition:
- Package wrr_arb_pkg:
  - state enum {IDLE, BURST}
  - localparam default weight floor (1)
  - function rr_first(req, start) returning index and found flag
- One natural sub-module: wrr_rr_pick. Combinational rotate/priority-encode with inputs request and last_selected, outputs pick index and any. It is instantiated once.
- Top level holds FSM, counter and output registers.

Test Plan:
- Reset, then request=8'h05, all weights=2, beat_done=1 every cycle: grants client 0 for 2 cycles, then client 2 for 2, then client 0 again; no bubble between bursts.
- request=8'hFF, weight[3]=0, others=1: each client is granted 1 beat in order 0..7; client 3 is granted exactly 1 beat.
- Client 1 granted with weight=4 and beat_done=1; stall=1 for 50 cycles after 2 beats: grant_id stays 1 and last_selected stays 1 throughout; after stall drops, 2 more beats are granted.
- Client 4 alone, weight=3: after 3 beats it is re-granted immediately with cnt reloaded; drop request[4] mid-burst: grant=0 next cycle and FSM=IDLE.
- Reset asserted during a burst of client 5: next cycle grant=0 and last_selected=7; a following request=8'h30 grants client 4 first.
- WRR_ARB_LOCK_EN defined, weight=1, lock=1 for 5 beats: grant held all 5 beats; released the cycle after lock=0 with beat_done=1.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// wrr_arb_pkg: shared types and the rotating first-requester search for the WRR burst arbiter.
package wrr_arb_pkg;

    typedef enum logic {IDLE, BURST} state_e;

    localparam int WEIGHT_FLOOR = 1;
    localparam int MAX_CLIENTS  = 32;
    localparam int MAX_IDX_W    = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scans offsets high to low so the smallest offset from start wins.
    function automatic rr_pick_t rr_first(input logic [MAX_CLIENTS-1:0] req,
                                          input logic [MAX_IDX_W-1:0] start,
                                          input int n);
        rr_pick_t    r;
        int unsigned s;
        r = '0;
        for (int k = MAX_CLIENTS - 1; k >= 0; k--) begin
            s = 32'(start) + 32'(k);
            if (s >= 32'(n)) s = s - 32'(n);
            if (k < n && req[s[MAX_IDX_W-1:0]]) r = '{found: 1'b1, idx: s[MAX_IDX_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_rr_pick.sv
// wrr_rr_pick: combinational rotating-priority pick starting just after last_i.
module wrr_rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int CLIENTS   = 8,
    parameter int CLIENTS_W = $clog2(CLIENTS)
) (
    input  logic [CLIENTS-1:0]   request_i,
    input  logic [CLIENTS_W-1:0] last_i,
    output logic [CLIENTS_W-1:0] pick_o,
    output logic                 any_o
);

    logic [MAX_IDX_W-1:0] start;
    rr_pick_t             r;
    logic                 unused_idx;

    assign start      = (last_i == CLIENTS_W'(CLIENTS - 1)) ? '0 : MAX_IDX_W'(last_i) + MAX_IDX_W'(1);
    assign r          = rr_first(MAX_CLIENTS'(request_i), start, CLIENTS);
    assign pick_o     = r.idx[CLIENTS_W-1:0];
    assign any_o      = r.found;
    assign unused_idx = ^r.idx;

endmodule

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin burst arbiter with global stall.
// Optional WRR_ARB_LOCK_EN adds lock_i, which holds a burst past its weight.
module wrr_burst_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int CLIENTS   = 8,
    parameter int CLIENTS_W = $clog2(CLIENTS),
    parameter int WEIGHT_W  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CLIENTS-1:0]           request_i,
    input  logic [CLIENTS*WEIGHT_W-1:0]  weight_i,
    input  logic                         beat_done_i,
    input  logic                         stall_i,
`ifdef WRR_ARB_LOCK_EN
    input  logic                         lock_i,
`endif
    output logic [CLIENTS-1:0]           grant_o,
    output logic                         grant_valid_o,
    output logic [CLIENTS_W-1:0]         grant_id_o,
    output logic [CLIENTS_W-1:0]         last_selected_o
);

    state_e               state_q, state_d;
    logic [CLIENTS-1:0]   grant_q, grant_d;
    logic [CLIENTS_W-1:0] id_q, id_d;
    logic [CLIENTS_W-1:0] last_q, last_d;
    logic [WEIGHT_W-1:0]  cnt_q, cnt_d;
    logic [CLIENTS_W-1:0] pick;
    logic                 any;
    logic [WEIGHT_W-1:0]  pick_w, load_cnt;
    logic                 locked, expire, rel;

`ifdef WRR_ARB_LOCK_EN
    assign locked = lock_i;
`else
    assign locked = 1'b0;
`endif

    wrr_rr_pick #(.CLIENTS(CLIENTS), .CLIENTS_W(CLIENTS_W)) u_pick (
        .request_i (request_i),
        .last_i    (last_q),
        .pick_o    (pick),
        .any_o     (any)
    );

    assign pick_w   = weight_i[pick*WEIGHT_W +: WEIGHT_W];
    assign load_cnt = (pick_w == '0) ? WEIGHT_W'(WEIGHT_FLOOR) : pick_w;
    assign expire   = beat_done_i && cnt_q == WEIGHT_W'(1) && !locked;
    assign rel      = !request_i[id_q] || expire;

    // The pick search starts after the current owner, so a lone requester re-wins itself.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (!stall_i) begin
            if (state_q == IDLE || rel) begin
                if (any) begin
                    state_d = BURST;
                    grant_d = CLIENTS'(1) << pick;
                    id_d    = pick;
                    last_d  = pick;
                    cnt_d   = load_cnt;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    cnt_d   = '0;
                end
            end else if (beat_done_i && cnt_q > WEIGHT_W'(1)) begin
                cnt_d = cnt_q - WEIGHT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            last_q  <= CLIENTS_W'(CLIENTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_valid_o   = |grant_q;
    assign grant_id_o      = id_q;
    assign last_selected_o = last_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter: directed scenarios plus randomized traffic against a behavioural WRR model.
module tb_wrr_burst_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int WW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  request;
    logic [N*WW-1:0] weight;
    logic          beat_done;
    logic          stall;
    logic          lock;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] last_selected;

    int n_checks = 0;
    int n_errors = 0;

    int m_owner;
    int m_cnt;
    int m_last;

    always #5 clock = ~clock;

    wrr_burst_arbiter #(.CLIENTS(N), .CLIENTS_W(IW), .WEIGHT_W(WW)) dut (
        .clock           (clock),
        .reset           (reset),
        .request_i       (request),
        .weight_i        (weight),
        .beat_done_i     (beat_done),
        .stall_i         (stall),
`ifdef WRR_ARB_LOCK_EN
        .lock_i          (lock),
`endif
        .grant_o         (grant),
        .grant_valid_o   (grant_valid),
        .grant_id_o      (grant_id),
        .last_selected_o (last_selected)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_weight(input int c);
        int w;
        w = int'(weight[c*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    // Behavioural model: owner/beats-left/last as integers, pick by a modulo scan.
    task automatic model_edge();
        bit lk, expired;
        int p;
`ifdef WRR_ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        if (reset) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N - 1;
        end else if (!stall) begin
            expired = beat_done && m_cnt == 1 && !lk;
            if (m_owner < 0 || !request[m_owner] || expired) begin
                p = -1;
                for (int k = 1; k <= N; k++)
                    if (p < 0 && request[(m_last + k) % N]) p = (m_last + k) % N;
                m_owner = p;
                m_cnt   = (p < 0) ? 0 : eff_weight(p);
                if (p >= 0) m_last = p;
            end else if (beat_done && m_cnt > 1) begin
                m_cnt--;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check("grant", 32'(grant), (m_owner < 0) ? 0 : (32'd1 << m_owner));
        check("grant_valid", 32'(grant_valid), (m_owner < 0) ? 0 : 1);
        check("grant_id", 32'(grant_id), (m_owner < 0) ? 0 : m_owner);
        check("last_selected", 32'(last_selected), m_last);
        check("onehot0", 32'($onehot0(grant)), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; request = '0; beat_done = 1'b0; stall = 1'b0; lock = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_all_weights(input int w);
        for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'(w);
    endtask

    initial begin
        int s1[5] = '{0, 0, 2, 2, 0};
        weight = '0;
        do_reset();
        check("rst_grant", 32'(grant), 0);
        check("rst_last", 32'(last_selected), N - 1);

        set_all_weights(2);
        request = 8'h05; beat_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s1_id", 32'(grant_id), s1[i]);
            check("s1_valid", 32'(grant_valid), 1);
        end

        do_reset();
        set_all_weights(1);
        weight[3*WW +: WW] = '0;
        request = 8'hFF; beat_done = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick();
            check("s2_id", 32'(grant_id), i);
        end

        do_reset();
        set_all_weights(4);
        request = 8'h02; beat_done = 1'b1;
        repeat (3) tick();
        stall = 1'b1;
        for (int i = 0; i < 50; i++) begin
            beat_done = 1'($urandom);
            request = 8'h02 | 8'($urandom);
            tick();
            check("s3_stall_id", 32'(grant_id), 1);
            check("s3_stall_last", 32'(last_selected), 1);
        end
        stall = 1'b0; beat_done = 1'b1; request = 8'h06;
        tick();
        check("s3_beat3", 32'(grant_id), 1);
        tick();
        check("s3_next", 32'(grant_id), 2);

        do_reset();
        set_all_weights(3);
        request = 8'h10; beat_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("s4_id", 32'(grant_id), 4);
            check("s4_valid", 32'(grant_valid), 1);
        end
        request = 8'h00;
        tick();
        check("s4_drop", 32'(grant), 0);

        do_reset();
        request = 8'h20; beat_done = 1'b0;
        repeat (2) tick();
        check("s5_id", 32'(grant_id), 5);
        reset = 1'b1;
        tick();
        check("s5_rst_grant", 32'(grant), 0);
        check("s5_rst_last", 32'(last_selected), 7);
        reset = 1'b0; request = 8'h30;
        tick();
        check("s5_first", 32'(grant_id), 4);

`ifdef WRR_ARB_LOCK_EN
        do_reset();
        set_all_weights(1);
        request = 8'h06; beat_done = 1'b1; lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("lk_hold", 32'(grant_id), 1);
        end
        lock = 1'b0;
        tick();
        check("lk_release", 32'(grant_id), 2);
`endif

        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset     = ($urandom_range(0, 199) == 0);
            stall     = ($urandom_range(0, 9) == 0);
            beat_done = ($urandom_range(0, 9) < 6);
            lock      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) weight = 32'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!request[i] && $urandom_range(0, 3) == 0) request[i] = 1'b1;
                else if (request[i] && m_owner == i && $urandom_range(0, 15) == 0) request[i] = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
